// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared FSM state type and stream-framing constants for imem_loader.
// Revision : 1.0
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam int unsigned c_hdr_bytes  = 2;
  localparam int unsigned c_word_bytes = 4;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs four accepted bytes little-endian into a word; one-cycle valid.
// Revision : 1.0
// ============================================================================
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam logic [1:0] c_last_lane = 2'(c_word_bytes - 1);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic [31:0] w_shift_nxt;

  // New byte enters at the top so the first byte ends up in bits [7:0].
  assign w_shift_nxt = {i_byte, r_shift[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clr) begin
        r_shift <= '0;
        r_cnt   <= '0;
        r_word  <= '0;
      end else if (i_byte_valid) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= r_cnt + 2'd1;
        if (r_cnt == c_last_lane) begin
          r_word       <= w_shift_nxt;
          r_word_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot loader: byte stream -> checksum-verified imem image; gates CPU reset.
// Revision : 1.0
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [15:0]   c_depth_n  = 16'(DEPTH);
  localparam logic [ADDR_W:0] c_word_one = (ADDR_W+1)'(1);

  state_t             r_state;
  logic               r_in_ready;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_cpu_reset;
  logic               r_done;
  logic               r_error;
  logic [ADDR_W:0]    r_word_cnt;
  logic [ADDR_W:0]    r_nwords;
  logic [1:0]         r_byte_cnt;
  logic [7:0]         r_csum;
  logic [7:0]         r_h0;

  logic               w_accept;
  logic               w_enter_hdr0;
  logic               w_pack_byte;
  logic [15:0]        w_hdr_n;
  logic [ADDR_W:0]    w_word_cnt_nxt;

  assign w_accept       = in_valid && r_in_ready;
  assign w_enter_hdr0   = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
  assign w_pack_byte    = w_accept && (r_state == ST_DATA);
  assign w_hdr_n        = {in_data, r_h0};
  assign w_word_cnt_nxt = r_word_cnt + c_word_one;

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .i_clr        (w_enter_hdr0),
    .i_byte_valid (w_pack_byte),
    .i_byte       (in_data),
    .o_word       (imem_wdata),
    .o_word_valid (imem_we)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_addr      <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_word_cnt  <= '0;
      r_nwords    <= '0;
      r_byte_cnt  <= '0;
      r_csum      <= '0;
      r_h0        <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state     <= ST_HDR0;
            r_in_ready  <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_csum      <= '0;
          end
        end
        ST_HDR0: begin
          if (w_accept) begin
            r_h0    <= in_data;
            r_state <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_accept) begin
            if (w_hdr_n > c_depth_n) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_nwords <= w_hdr_n[ADDR_W:0];
              r_state  <= (w_hdr_n == 16'd0) ? ST_CHK : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // The packer emits this word next cycle; latch its address alongside.
            if (r_byte_cnt == 2'd3) begin
              r_addr     <= r_word_cnt[ADDR_W-1:0];
              r_word_cnt <= w_word_cnt_nxt;
              if (w_word_cnt_nxt == r_nwords) begin
                r_state <= ST_CHK;
              end
            end
          end
        end
        ST_CHK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign imem_addr = r_addr;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader with a stream-level model.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       imem_we;
  logic [5:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       error;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stream-level model: position within the current load, header word count,
  // running XOR and the bytes of the word being collected.
  bit          m_loading = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_err     = 1'b0;
  int          m_pos     = 0;
  int          m_n       = 0;
  int          m_k       = 0;
  logic [7:0]  m_h0      = 8'h00;
  logic [7:0]  m_x       = 8'h00;
  logic [7:0]  m_b [4];
  bit          p_we      = 1'b0;
  logic [5:0]  p_addr    = 6'd0;
  logic [31:0] p_wdata   = 32'd0;

  logic [31:0] obs_mem [64];
  int          obs_writes = 0;
  int          obs_last   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
      m_err     = 1'b0;
      p_we      = 1'b0;
    end
    chk("in_ready",  32'(in_ready),  32'(m_loading));
    chk("imem_we",   32'(imem_we),   32'(p_we));
    if (p_we) begin
      chk("imem_addr",  32'(imem_addr), 32'(p_addr));
      chk("imem_wdata", imem_wdata,     p_wdata);
    end
    chk("done",      32'(done),      32'(m_done));
    chk("error",     32'(error),     32'(m_err));
    chk("cpu_reset", 32'(cpu_reset), 32'(!m_done));
    if (imem_we) begin
      obs_mem[imem_addr] = imem_wdata;
      obs_writes++;
      obs_last = 32'(imem_addr);
    end
    p_we = 1'b0;
    if (reset) begin
      if (!m_loading && start) begin
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_pos     = 0;
        m_x       = 8'h00;
      end else if (m_loading && in_valid) begin
        if (m_pos == 0) begin
          m_h0 = in_data;
        end else if (m_pos == 1) begin
          m_n = 32'({in_data, m_h0});
          if (m_n > 64) begin
            m_loading = 1'b0;
            m_err     = 1'b1;
          end
        end else if (m_pos < 2 + 4 * m_n) begin
          m_k = m_pos - 2;
          m_b[m_k % 4] = in_data;
          m_x = m_x ^ in_data;
          if (m_k % 4 == 3) begin
            p_we    = 1'b1;
            p_addr  = 6'(m_k / 4);
            p_wdata = {m_b[3], m_b[2], m_b[1], m_b[0]};
          end
        end else begin
          m_loading = 1'b0;
          if (in_data == m_x) m_done = 1'b1;
          else                m_err  = 1'b1;
        end
        m_pos++;
      end
    end
  end

  logic [7:0] stream [$];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input bit stall, input int start_at);
    int  i;
    int  cyc;
    bit  acc;
    i   = 0;
    cyc = 0;
    while (i < stream.size()) begin
      in_data  = stream[i];
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (i == start_at);
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
      if (cyc > 2000) begin
        chk("send_timeout", 32'(i), 32'(stream.size()));
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_nominal(input logic [7:0] c);
    stream = '{8'h03, 8'h00, 8'h13, 8'h02, 8'h00, 8'h01, 8'h93, 8'h00,
               8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, c};
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
  endtask

  int base;

  initial begin
    #2 reset = 1'b0;
    #1 check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);

    // Nominal 3-word load
    base = obs_writes;
    pulse_start();
    set_nominal(8'hA1);
    send(1'b0, -1);
    chk("nom_done_next_cycle", 32'(done),      32'd1);
    chk("nom_cpu_reset_low",   32'(cpu_reset), 32'd0);
    idle(2);
    chk("nom_writes", 32'(obs_writes - base), 32'd3);
    chk("nom_w0", obs_mem[0], 32'h01000213);
    chk("nom_w1", obs_mem[1], 32'h00100093);
    chk("nom_w2", obs_mem[2], 32'h00200113);

    // Bad checksum
    base = obs_writes;
    pulse_start();
    set_nominal(8'hA0);
    send(1'b0, -1);
    idle(2);
    chk("bad_writes",    32'(obs_writes - base), 32'd3);
    chk("bad_error",     32'(error),     32'd1);
    chk("bad_done",      32'(done),      32'd0);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);

    // Oversize header: further valid bytes must not be taken
    base = obs_writes;
    pulse_start();
    stream = '{8'h41, 8'h00};
    send(1'b0, -1);
    chk("over_error_next_cycle", 32'(error),    32'd1);
    chk("over_in_ready",         32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h13;
    idle(3);
    in_valid = 1'b0;
    chk("over_writes", 32'(obs_writes - base), 32'd0);

    // Full-depth image, bytes j ^ 0x5A: checksum folds to 0x00
    base = obs_writes;
    pulse_start();
    stream = '{8'h40, 8'h00};
    for (int j = 0; j < 256; j++) stream.push_back(8'(j) ^ 8'h5A);
    stream.push_back(8'h00);
    send(1'b0, -1);
    idle(2);
    chk("full_writes", 32'(obs_writes - base), 32'd64);
    chk("full_last",   32'(obs_last), 32'd63);
    chk("full_w0",     obs_mem[0],  32'h59585B5A);
    chk("full_w63",    obs_mem[63], 32'hA5A4A7A6);
    chk("full_done",   32'(done),   32'd1);

    // Empty image
    base = obs_writes;
    pulse_start();
    stream = '{8'h00, 8'h00, 8'h00};
    send(1'b0, -1);
    idle(2);
    chk("zero_writes", 32'(obs_writes - base), 32'd0);
    chk("zero_done",   32'(done), 32'd1);

    // Stalled stream with start poked mid-data
    base = obs_writes;
    for (int j = 0; j < 3; j++) obs_mem[j] = 32'd0;
    pulse_start();
    set_nominal(8'hA1);
    send(1'b1, 6);
    idle(2);
    chk("stall_writes", 32'(obs_writes - base), 32'd3);
    chk("stall_w0", obs_mem[0], 32'h01000213);
    chk("stall_w1", obs_mem[1], 32'h00100093);
    chk("stall_w2", obs_mem[2], 32'h00200113);
    chk("stall_done", 32'(done), 32'd1);

    // Reset after 6 data bytes
    pulse_start();
    stream = '{8'h03, 8'h00, 8'h13, 8'h02, 8'h00, 8'h01, 8'h93, 8'h00};
    send(1'b0, -1);
    #1 reset = 1'b0;
    #1 check_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    base = obs_writes;
    for (int j = 0; j < 3; j++) obs_mem[j] = 32'd0;
    pulse_start();
    set_nominal(8'hA1);
    send(1'b0, -1);
    idle(2);
    chk("after_rst_writes", 32'(obs_writes - base), 32'd3);
    chk("after_rst_w0", obs_mem[0], 32'h01000213);
    chk("after_rst_w2", obs_mem[2], 32'h00200113);
    chk("after_rst_done", 32'(done), 32'd1);

    // Reload from DONE with a 1-word image
    base = obs_writes;
    pulse_start();
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_done",      32'(done),      32'd0);
    stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
    send(1'b0, -1);
    idle(2);
    chk("reload_writes", 32'(obs_writes - base), 32'd1);
    chk("reload_w0",     obs_mem[0], 32'h00500513);
    chk("reload_final",  32'(done),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the CPU `top`. It accepts a byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes them sequentially into instruction memory from word 0, holding the CPU in reset until a complete, checksum-verified image is present. It replaces hierarchical memory pokes as the way programs get into `imem`.

## Interface
Parameters:
- `DEPTH`, 64: instruction memory size in 32-bit words.
- `ADDR_W`, 6: word-address width; must equal clog2(`DEPTH`).

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk`).
- `start`  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  `ADDR_W`  word address for the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_reset`  out  1  active-high reset to `top`; asserted until a verified load completes.
- `done`  out  1  image loaded and verified; held until next `start` or reset.
- `error`  out  1  load failed (oversize or checksum); held until next `start` or reset.

## Operation
- Stream format: header byte H0, header byte H1 giving word count N = {H1,H0}, then 4·N data bytes, then one checksum byte C.
- Word assembly: bytes b0,b1,b2,b3 form {b3,b2,b1,b0}; word i goes to `imem_addr` = i.
- C must equal the XOR of all 4·N data bytes. Header bytes are excluded from the checksum.
- FSM states: IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR.
- IDLE → HDR0 on `start`.
- HDR0 → HDR1 on byte accept.
- HDR1 → ERR on byte accept if N > `DEPTH`. Otherwise → CHK if N == 0, else → DATA.
- DATA → CHK when byte 4·N is accepted.
- CHK → DONE on accept if the byte matches the checksum, else → ERR.
- DONE and ERR → HDR0 on `start`. Entering HDR0 clears the word counter, byte counter, checksum, `done` and `error`, and re-asserts `cpu_reset`.
- `start` in HDR0, HDR1, DATA or CHK is ignored.
- `in_ready` = 1 exactly in HDR0, HDR1, DATA and CHK. A byte is accepted only when `in_valid` && `in_ready`.
- `in_valid` gaps of any length stall the FSM with no state change.
- Word counter is `ADDR_W`+1 bits wide. N == `DEPTH` is legal and writes addresses 0..`DEPTH`-1 with no wrap.
- An N ≤ `DEPTH` load never writes above N-1.
- Reset values: state IDLE, `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_reset` 1, `done` 0, `error` 0.
- Reset mid-load: abort immediately and return to reset values. Partially written memory is not cleared.
- `cpu_reset` stays 1 after ERR.

## Timing
- All outputs are registered.
- Fourth byte of a word accepted in cycle k → `imem_we` = 1 in cycle k+1 only, with `imem_addr` and `imem_wdata` valid in that same cycle.
- Fully streaming input produces one write every 4 cycles.
- `imem_we` is never high on two consecutive cycles.
- Checksum byte accepted in cycle m → `done` = 1 and `cpu_reset` = 0 in cycle m+1.
- A correct checksum implies the final `imem_we` occurred in cycle m or earlier, so memory is complete before `cpu_reset` falls.
- Error detection: ERR is entered, and `error` = 1, in the cycle after the offending byte is accepted. `in_ready` drops in that same cycle.
- Minimum load time: 2 + 4·N + 1 accepted bytes, plus 1 cycle to DONE.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum (IDLE..ERR);
  - the header length constant (2);
  - the bytes-per-word constant (4).
- One natural sub-module: `byte_packer`. It shifts 4 accepted bytes into a 32-bit word and emits a one-cycle `word_valid`, with a synchronous clear driven on entry to HDR0.
- The FSM, counters and checksum stay in `imem_loader`.

## Test plan
- **Nominal 3-word load.** `start`, then bytes 03 00 13 02 00 01 93 00 10 00 13 01 20 00 A1 streamed back to back.
  - Expect writes: addr 0 = 0x01000213, addr 1 = 0x00100093, addr 2 = 0x00200113.
  - Then `done` = 1 and `cpu_reset` = 0 one cycle after A1.
- **Bad checksum.** Same stream with final byte 0xA0.
  - Expect all 3 writes, then `error` = 1, `cpu_reset` stays 1, `done` = 0.
- **Oversize and boundary counts.**
  - Header 41 00 (N = 65, `DEPTH` = 64): ERR one cycle after H1, zero writes, `in_ready` = 0.
  - Header 40 00: 64 writes, last at addr 63.
  - Header 00 00 followed by C = 00: DONE with no writes.
- **Stalls and ignored start.** Nominal stream with `in_valid` randomly low about 50% of cycles, and `start` pulsed during DATA.
  - Expect identical write sequence and final state; `start` has no effect.
- **Reset mid-load.** Assert `reset` after 6 data bytes.
  - Expect all outputs at reset values asynchronously.
  - Then `start` plus the nominal stream loads correctly from addr 0.
- **Reload after DONE.** From DONE, pulse `start`.
  - Expect `cpu_reset` = 1 and `done` = 0 next cycle.
  - A new 1-word image (01 00 13 05 50 00 46) writes 0x00500513 to addr 0 and ends in DONE.
